// File: rtl/ogege_video_pkg.sv
// rtl/ogege_video_pkg.sv - video timing constants and bitmap fetch FSM states
package ogege_video_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BM_WIDTH = 320;
  localparam int ADDR_W   = 24;
  localparam int WORD_W   = 9;
  localparam int LINE_W   = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
endpackage

// File: rtl/bitmap_line_fetch_if.sv
// rtl/bitmap_line_fetch_if.sv - PSRAM ownership and single-word read port
interface bitmap_line_fetch_if;
  import ogege_video_pkg::*;
  logic              req;
  logic              gnt;
  logic              busy;
  logic              done;
  logic [15:0]       dout;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;

  modport master (output req, stb, we, addr, input gnt, busy, done, dout);
  modport slave  (input req, stb, we, addr, output gnt, busy, done, dout);
endinterface

// File: rtl/line_ram_2x.sv
// rtl/line_ram_2x.sv - two-bank line buffer, fetch write port and registered display read port
module line_ram_2x
  import ogege_video_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_wbank,
  input  logic [WORD_W-1:0] i_waddr,
  input  logic [11:0]       i_wdata,
  input  logic              i_rbank,
  input  logic [WORD_W-1:0] i_raddr,
  output logic [11:0]       o_rdata
);
  localparam int DEPTH = 2 * BM_WIDTH;

  logic [11:0] r_mem [DEPTH];
  logic [9:0]  w_wa;
  logic [9:0]  w_ra;

  assign w_wa = i_wbank ? 10'(BM_WIDTH) + {1'b0, i_waddr} : {1'b0, i_waddr};
  assign w_ra = i_rbank ? 10'(BM_WIDTH) + {1'b0, i_raddr} : {1'b0, i_raddr};

  // No reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[w_wa] <= i_wdata;
    o_rdata <= r_mem[w_ra];
  end
endmodule

// File: rtl/bitmap_line_fetch.sv
// rtl/bitmap_line_fetch.sv - prefetches one bitmap line per scan pair and replays it pixel-doubled
module bitmap_line_fetch
  import ogege_video_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [ADDR_W-1:0]   i_base,
  input  logic [11:0]         i_bg_color,
  input  logic [8:0]          i_scan_row,
  input  logic [9:0]          i_scan_column,
  bitmap_line_fetch_if.master io_psram,
  output logic [11:0]         o_color,
  output logic                o_underrun
);
  fetch_state_t      r_state, w_state;
  logic [LINE_W-1:0] r_line, w_line, w_trig_line;
  logic [WORD_W-1:0] r_word, w_word, w_ridx;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [1:0]        r_valid, w_valid;
  logic              r_restart, w_restart;
  logic              w_trig, w_last, w_issue, w_wr, w_active;
  logic [17:0]       w_word_idx;
  logic              r_sel, r_underrun;
  logic [11:0]       r_bg, w_rdata;
  logic              w_unused_dout;

  assign w_trig = i_enable && (i_scan_column == 10'(H_ACTIVE)) &&
                  ((i_scan_row == 9'(V_ACTIVE - 1)) ||
                   (i_scan_row[0] && (i_scan_row < 9'(V_ACTIVE - 1))));
  assign w_trig_line = (i_scan_row == 9'(V_ACTIVE - 1)) ? '0 : LINE_W'((i_scan_row + 9'd1) >> 1);
  assign w_last      = (r_word == WORD_W'(BM_WIDTH - 1));
  assign w_word_idx  = 18'(r_line) * 18'(BM_WIDTH) + 18'(r_word);

  always_comb begin
    w_state   = r_state;
    w_line    = r_line;
    w_word    = r_word;
    w_base    = r_base;
    w_valid   = r_valid;
    w_restart = r_restart;
    w_issue   = 1'b0;
    w_wr      = 1'b0;
    case (r_state)
      IDLE: if (w_trig) w_state = REQ;
      REQ: begin
        if (w_trig) w_state = REQ;
        else if (!i_enable) w_state = IDLE;
        else if (io_psram.gnt && !io_psram.busy) begin
          w_issue = 1'b1;
          w_state = WAIT;
        end
      end
      WAIT: begin
        // A new trigger or disable abandons the line; an in-flight read must still be absorbed.
        if (w_trig) w_state = io_psram.done ? REQ : DRAIN;
        else if (!i_enable) w_state = io_psram.done ? IDLE : DRAIN;
        else if (io_psram.done) begin
          w_wr = 1'b1;
          if (w_last) begin
            w_valid[r_line[0]] = 1'b1;
            w_state = IDLE;
          end else begin
            w_word  = r_word + 1'b1;
            w_state = REQ;
          end
        end
      end
      DRAIN: if (io_psram.done) w_state = ((r_restart || w_trig) && i_enable) ? REQ : IDLE;
      default: w_state = IDLE;
    endcase
    if (w_trig) begin
      w_line    = w_trig_line;
      w_word    = '0;
      w_restart = 1'b1;
      w_valid[w_trig_line[0]] = 1'b0;
      if (i_scan_row == 9'(V_ACTIVE - 1)) w_base = i_base;
    end
    if (!i_enable) begin
      w_valid   = '0;
      w_restart = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_line    <= '0;
      r_word    <= '0;
      r_base    <= '0;
      r_valid   <= '0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_line    <= w_line;
      r_word    <= w_word;
      r_base    <= w_base;
      r_valid   <= w_valid;
      r_restart <= w_restart;
    end
  end

  assign io_psram.req  = (r_state != IDLE);
  assign io_psram.stb  = w_issue;
  assign io_psram.we   = 1'b0;
  assign io_psram.addr = r_base + ADDR_W'({w_word_idx, 1'b0});
  assign w_unused_dout = ^io_psram.dout[15:12];

  assign w_active = (i_scan_row < 9'(V_ACTIVE)) && (i_scan_column < 10'(H_ACTIVE));
  assign w_ridx   = w_active ? i_scan_column[9:1] : '0;

  line_ram_2x u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr),
    .i_wbank (r_line[0]),
    .i_waddr (r_word),
    .i_wdata (io_psram.dout[11:0]),
    .i_rbank (i_scan_row[1]),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // Select and background are registered alongside the RAM read to keep one-cycle latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel      <= 1'b0;
      r_bg       <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_sel      <= i_enable && w_active && r_valid[i_scan_row[1]];
      r_bg       <= i_bg_color;
      r_underrun <= i_enable && w_active && (i_scan_column == 10'd0) &&
                    !i_scan_row[0] && !r_valid[i_scan_row[1]];
    end
  end

  assign o_color    = r_sel ? w_rdata : r_bg;
  assign o_underrun = r_underrun;
endmodule

// File: tb/tb_bitmap_line_fetch.sv
// tb/tb_bitmap_line_fetch.sv - table-driven and randomized checks of the scanline prefetcher
module tb_bitmap_line_fetch;
  import ogege_video_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] base = '0;
  logic [11:0] bg = '0;
  logic [8:0]  row = '0;
  logic [9:0]  col = 10'd700;
  logic [11:0] color;
  logic        underrun;

  bitmap_line_fetch_if psram();

  bitmap_line_fetch dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_base        (base),
    .i_bg_color    (bg),
    .i_scan_row    (row),
    .i_scan_column (col),
    .io_psram      (psram.master),
    .o_color       (color),
    .o_underrun    (underrun)
  );

  always #5 clk = ~clk;

  // PSRAM model: bitmap word k of the frame holds k ^ key; done arrives lat clocks after stb.
  int          lat = 2;
  logic        gnt_en = 1'b1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [23:0] paddr = '0;
  logic [23:0] mbase = '0;
  logic [15:0] key = '0;
  int          stb_cnt = 0;
  int          req_cycles = 0;
  int          ovl_err = 0;
  logic [23:0] addr_log[$];

  assign psram.gnt  = gnt_en;
  assign psram.busy = pend;

  always @(posedge clk) begin
    psram.done <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        psram.done <= 1'b1;
        psram.dout <= 16'((paddr - mbase) >> 1) ^ key;
        pend <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (psram.stb) begin
      if (pend && cnt > 1) ovl_err++;
      pend  <= 1'b1;
      cnt   <= lat - 1;
      paddr <= psram.addr;
      stb_cnt++;
      addr_log.push_back(psram.addr);
    end
    if (psram.req) req_cycles++;
  end

  int n_chk = 0;
  int n_fail = 0;
  int resident[2] = '{-1, -1};

  typedef struct {
    int          r;
    int          c;
    logic [11:0] color;
    logic        und;
  } vec_t;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int line, input int x);
    logic [15:0] w;
    w = 16'(line * BM_WIDTH + x) ^ key;
    return w[11:0];
  endfunction

  function automatic logic [11:0] exp_color(input int r, input int c);
    int p;
    if (!enable || r >= V_ACTIVE || c >= H_ACTIVE) return bg;
    p = (r >> 1) & 1;
    if (resident[p] < 0) return bg;
    return pix(resident[p], c >> 1);
  endfunction

  function automatic logic exp_underrun(input int r, input int c);
    return enable && r < V_ACTIVE && c == 0 && (r % 2 == 0) && resident[(r >> 1) & 1] < 0;
  endfunction

  task automatic probe(input string nm, input int r, input int c);
    logic [11:0] ec;
    logic        eu;
    row = 9'(r);
    col = 10'(c);
    ec  = exp_color(r, c);
    eu  = exp_underrun(r, c);
    tick();
    chk({nm, " color"}, 32'(color), 32'(ec));
    chk({nm, " underrun"}, 32'(underrun), 32'(eu));
  endtask

  task automatic rand_probes(input string nm, input int n, input int rmax);
    for (int i = 0; i < n; i++) begin
      int c;
      c = $urandom_range(0, 798);
      if (c >= H_ACTIVE) c++;
      probe(nm, $urandom_range(0, rmax), c);
    end
  endtask

  task automatic trigger(input int r);
    row = 9'(r);
    col = 10'(H_ACTIVE);
    tick();
    row = '0;
    col = 10'd700;
  endtask

  task automatic wait_fetch(input string nm, input int maxc);
    for (int i = 0; i < maxc && psram.req; i++) tick();
    chk({nm, " fetch end"}, 32'(psram.req), 32'd0);
  endtask

  task automatic wait_stb(input int maxc);
    for (int i = 0; i < maxc && stb_cnt == 0; i++) tick();
    chk("first stb seen", 32'(stb_cnt > 0), 32'd1);
  endtask

  task automatic chk_seq(input string nm, input int line, input int first);
    int bad;
    bad = 0;
    for (int i = first; i < addr_log.size(); i++)
      if (addr_log[i] != 24'h000100 + 24'((line * BM_WIDTH + i - first) * 2)) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  task automatic clear_log();
    addr_log.delete();
    stb_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{0,   10,  12'h005, 1'b0};
    vecs[1] = '{1,   10,  12'h005, 1'b0};
    vecs[2] = '{0,   0,   12'h000, 1'b0};
    vecs[3] = '{1,   639, 12'h13F, 1'b0};
    vecs[4] = '{0,   638, 12'h13F, 1'b0};
    vecs[5] = '{2,   0,   12'h00F, 1'b1};
    vecs[6] = '{3,   100, 12'h00F, 1'b0};
    vecs[7] = '{0,   641, 12'h00F, 1'b0};
    vecs[8] = '{480, 0,   12'h00F, 1'b0};
    vecs[9] = '{4,   20,  12'h00A, 1'b0};

    repeat (3) tick();
    chk("reset req", 32'(psram.req), 0);
    chk("reset stb", 32'(psram.stb), 0);
    chk("reset we", 32'(psram.we), 0);
    chk("reset addr", 32'(psram.addr), 0);
    chk("reset color", 32'(color), 0);
    chk("reset underrun", 32'(underrun), 0);
    rst = 1'b0;
    tick();

    // Frame-start fetch of line 0 with a fast PSRAM.
    bg = 12'h00F; base = 24'h000100; mbase = 24'h000100; key = '0; lat = 2; enable = 1'b1;
    clear_log();
    trigger(V_ACTIVE - 1);
    resident[0] = -1;
    chk("t1 req raised", 32'(psram.req), 1);
    wait_fetch("t1", 2000);
    chk("t1 stb count", 32'(stb_cnt), 320);
    chk_seq("t1 addr seq", 0, 0);
    chk("t1 last addr", 32'(addr_log[319]), 32'h00037E);
    resident[0] = 0;
    for (int i = 0; i < 10; i++) begin
      row = 9'(vecs[i].r);
      col = 10'(vecs[i].c);
      tick();
      chk($sformatf("t1 vec%0d color", i), 32'(color), 32'(vecs[i].color));
      chk($sformatf("t1 vec%0d underrun", i), 32'(underrun), 32'(vecs[i].und));
    end
    rand_probes("t1 rand", 30, 524);

    // Row 3 trigger fetches line 2 into bank 0.
    clear_log();
    trigger(3);
    resident[0] = -1;
    wait_fetch("t2", 2000);
    chk("t2 stb count", 32'(stb_cnt), 320);
    chk("t2 first addr", 32'(addr_log[0]), 32'h000600);
    chk_seq("t2 addr seq", 2, 0);
    resident[0] = 2;
    probe("t2 r4c0", 4, 0);
    probe("t2 r5c639", 5, 639);
    chk("t2 r5c639 abs", 32'(color), 32'h3BF);
    rand_probes("t2 rand", 20, 7);

    // Slow PSRAM: line 1 still in flight when row 2 starts.
    lat = 8;
    clear_log();
    trigger(1);
    resident[1] = -1;
    probe("t3 r2c0", 2, 0);
    chk("t3 underrun abs", 32'(underrun), 1);
    chk("t3 bg abs", 32'(color), 32'h00F);
    probe("t3 r2c1", 2, 1);
    wait_fetch("t3", 4000);
    resident[1] = 1;
    probe("t3 r2c0 after", 2, 0);

    // Trigger while a read is outstanding: the late word is dropped and line 4 restarts at word 0.
    clear_log();
    trigger(5);
    resident[1] = -1;
    wait_stb(20);
    tick(); tick();
    trigger(7);
    resident[0] = -1;
    wait_fetch("t4", 5000);
    chk("t4 stb count", 32'(stb_cnt), 321);
    chk("t4 aborted addr", 32'(addr_log[0]), 32'h000100 + 32'(3 * 640));
    chk("t4 restart addr", 32'(addr_log[1]), 32'h000B00);
    chk_seq("t4 addr seq", 4, 1);
    resident[0] = 4;
    probe("t4 r8c0", 8, 0);
    probe("t4 r6c0", 6, 0);
    rand_probes("t4 rand", 15, 11);

    // Grant withheld for 100 clocks.
    lat = 2; gnt_en = 1'b0;
    clear_log();
    req_cycles = 0;
    trigger(9);
    resident[1] = -1;
    repeat (100) tick();
    chk("t5 no stb", 32'(stb_cnt), 0);
    chk("t5 req held", 32'(req_cycles), 100);
    gnt_en = 1'b1;
    wait_fetch("t5", 2000);
    chk("t5 stb count", 32'(stb_cnt), 320);
    chk_seq("t5 addr seq", 5, 0);
    resident[1] = 5;
    probe("t5 r10c0", 10, 0);
    probe("t5 r11c639", 11, 639);

    // Reset during WAIT, then a disabled frame.
    lat = 8;
    clear_log();
    trigger(11);
    wait_stb(20);
    tick();
    rst = 1'b1;
    #1;
    chk("t6 req", 32'(psram.req), 0);
    chk("t6 stb", 32'(psram.stb), 0);
    chk("t6 addr", 32'(psram.addr), 0);
    chk("t6 color", 32'(color), 0);
    chk("t6 underrun", 32'(underrun), 0);
    resident[0] = -1; resident[1] = -1;
    tick(); tick();
    rst = 1'b0; enable = 1'b0;
    req_cycles = 0;
    clear_log();
    repeat (12) tick();
    for (int r = 1; r < V_ACTIVE; r += 2) trigger(r);
    trigger(V_ACTIVE - 1);
    rand_probes("t6 rand", 20, 524);
    chk("t6 no req", 32'(req_cycles), 0);
    chk("t6 no stb", 32'(stb_cnt), 0);
    chk("one outstanding", 32'(ovl_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
